// File: rtl/fdtd_src_gen.sv
// Excitation-table playback for FDTD source injection: one table sample per
// time step, scaled by a latched fixed-point amplitude, three-stage pipeline.
module fdtd_src_gen #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int TBL_AW          = 8,
  parameter int AMP_SHIFT       = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              tbl_we,
  input  logic [TBL_AW-1:0]                 tbl_waddr,
  input  logic signed [FDTD_DATA_WIDTH-1:0] tbl_wdata,
  input  logic signed [FDTD_DATA_WIDTH-1:0] amp,
  input  logic [TBL_AW:0]                   n_steps,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              step_req,
  output logic                              busy,
  output logic signed [FDTD_DATA_WIDTH-1:0] Jz_o,
  output logic                              Jz_valid,
  output logic                              done
);

  localparam int W = FDTD_DATA_WIDTH;
  localparam logic signed [2*W-1:0] RND  = {{(2*W-1){1'b0}}, 1'b1} << (AMP_SHIFT-1);
  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  state_t state, state_nx;

  logic signed [W-1:0]   mem [0:(2**TBL_AW)-1];
  logic signed [W-1:0]   amp_r;
  logic [TBL_AW:0]       len_r;
  logic [TBL_AW-1:0]     idx;
  logic                  accept;
  logic                  arm;
  logic                  last_hit;

  logic                  vld_p1, last_p1, zero_p1;
  logic signed [W-1:0]   rdata_p1;
  logic                  vld_p2, last_p2;
  logic signed [2*W-1:0] prod_p2;

  function automatic logic signed [2*W-1:0] mul_full(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
    logic signed [2*W-1:0] ax, bx;
    ax = {{W{a[W-1]}}, a};
    bx = {{W{b[W-1]}}, b};
    return ax * bx;
  endfunction

  // Round half up, arithmetic shift out the fraction, clamp to W signed bits.
  function automatic logic signed [W-1:0] round_sat(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] r, s;
    r = p + RND;
    s = r >>> AMP_SHIFT;
    if (s > MAXV)      return MAXV[W-1:0];
    else if (s < MINV) return MINV[W-1:0];
    else               return s[W-1:0];
  endfunction

  assign busy     = (state != IDLE);
  assign last_hit = ({1'b0, idx} == (len_r - {{TBL_AW{1'b0}}, 1'b1}));
  assign arm      = (state == IDLE) && start && !stop;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (n_steps == '0) ? TAIL : RUN;
      RUN: begin
        if (step_req) begin
          accept = 1'b1;
          if (last_hit) state_nx = TAIL;
        end
      end
      TAIL:    if (step_req) accept = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (stop) begin
      state_nx = IDLE;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      Jz_valid <= 1'b0;
      done     <= 1'b0;
      Jz_o     <= '0;
    end else begin
      state <= state_nx;
      if (arm) idx <= '0;
      else if (accept && state == RUN) idx <= idx + {{(TBL_AW-1){1'b0}}, 1'b1};
      // S0 -> S1: read issue
      vld_p1   <= accept;
      last_p1  <= accept && (state == RUN) && last_hit;
      // S1 -> S2: multiply; stop flushes every stage
      vld_p2   <= vld_p1 && !stop;
      last_p2  <= last_p1 && !stop;
      // S2 -> out: round/shift/saturate
      Jz_valid <= vld_p2 && !stop;
      done     <= vld_p2 && last_p2 && !stop;
      if (vld_p2 && !stop) Jz_o <= round_sat(prod_p2);
    end
  end

  // Datapath registers and table RAM carry no reset.
  always_ff @(posedge CLK) begin
    if (arm) begin
      amp_r <= amp;
      len_r <= n_steps;
    end
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    if (accept) begin
      rdata_p1 <= mem[idx];
      zero_p1  <= (state == TAIL);
    end
    prod_p2 <= mul_full(zero_p1 ? '0 : rdata_p1, amp_r);
  end

endmodule

// File: tb/tb_fdtd_src_gen.sv
// Directed bench for fdtd_src_gen: playback, rounding, saturation, TAIL zeros,
// stop flush and mid-run reset.
module tb_fdtd_src_gen;

  logic               CLK = 1'b0;
  logic               RST;
  logic               tbl_we;
  logic [7:0]         tbl_waddr;
  logic signed [31:0] tbl_wdata;
  logic signed [31:0] amp;
  logic [8:0]         n_steps;
  logic               start, stop, step_req;
  logic               busy;
  logic signed [31:0] Jz_o;
  logic               Jz_valid;
  logic               done;

  int errors = 0;
  int checks = 0;

  fdtd_src_gen dut (
    .CLK(CLK), .RST(RST), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata), .amp(amp), .n_steps(n_steps), .start(start),
    .stop(stop), .step_req(step_req), .busy(busy), .Jz_o(Jz_o),
    .Jz_valid(Jz_valid), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic signed [31:0] d);
    tbl_we = 1'b1; tbl_waddr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic arm(input logic signed [31:0] a, input logic [8:0] n);
    amp = a; n_steps = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // One isolated step: valid must appear exactly three edges after the request.
  task automatic play_one(input string tag, input logic signed [31:0] exp,
                          input logic exp_done);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    check({tag, "_early"}, {31'b0, Jz_valid}, 32'sd0);
    tick();
    check({tag, "_vld"}, {31'b0, Jz_valid}, 32'sd1);
    check({tag, "_jz"}, Jz_o, exp);
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    tick();
    check({tag, "_vld_off"}, {31'b0, Jz_valid}, 32'sd0);
    check({tag, "_hold"}, Jz_o, exp);
  endtask

  logic signed [31:0] half_exp [4];

  initial begin
    RST = 1'b1; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
    amp = '0; n_steps = '0; start = 1'b0; stop = 1'b0; step_req = 1'b0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'sd0);
    check("rst_vld", {31'b0, Jz_valid}, 32'sd0);
    check("rst_done", {31'b0, done}, 32'sd0);
    check("rst_jz", Jz_o, 32'sd0);
    RST = 1'b0;
    tick();

    // Unity gain, spaced steps, then a TAIL zero
    wr(8'd0, 32'sd10); wr(8'd1, -32'sd20); wr(8'd2, 32'sd30); wr(8'd3, -32'sd40);
    arm(32'sd65536, 9'd4);
    check("busy_rise", {31'b0, busy}, 32'sd1);
    play_one("u0", 32'sd10, 1'b0);
    play_one("u1", -32'sd20, 1'b0);
    play_one("u2", 32'sd30, 1'b0);
    play_one("u3", -32'sd40, 1'b1);
    play_one("tail", 32'sd0, 1'b0);
    check("tail_busy", {31'b0, busy}, 32'sd1);
    halt();
    check("stop_busy", {31'b0, busy}, 32'sd0);

    // Half gain, back-to-back
    half_exp[0] = 32'sd5; half_exp[1] = -32'sd10;
    half_exp[2] = 32'sd15; half_exp[3] = -32'sd20;
    arm(32'sd32768, 9'd4);
    for (int i = 0; i < 8; i++) begin
      step_req = (i < 4);
      tick();
      if (i >= 2 && i <= 5) begin
        check($sformatf("b2b_vld%0d", i), {31'b0, Jz_valid}, 32'sd1);
        check($sformatf("b2b_jz%0d", i), Jz_o, half_exp[i-2]);
        check($sformatf("b2b_done%0d", i), {31'b0, done}, (i == 5) ? 32'sd1 : 32'sd0);
      end else begin
        check($sformatf("b2b_idle%0d", i), {31'b0, Jz_valid}, 32'sd0);
      end
    end
    step_req = 1'b0;
    halt();

    // 3 * 0.5 = 1.5 rounds up to 2
    wr(8'd0, 32'sd3);
    arm(32'sd32768, 9'd1);
    play_one("rnd", 32'sd2, 1'b1);
    halt();

    // Saturation at both rails with gain 2.0
    wr(8'd0, 32'h7FFFFFFF);
    arm(32'h00020000, 9'd1);
    play_one("satp", 32'h7FFFFFFF, 1'b1);
    halt();
    wr(8'd0, 32'h80000000);
    arm(32'h00020000, 9'd1);
    play_one("satn", 32'h80000000, 1'b1);
    halt();

    // Zero-length playback goes straight to TAIL
    arm(32'sd65536, 9'd0);
    check("zl_busy", {31'b0, busy}, 32'sd1);
    play_one("zl", 32'sd0, 1'b0);
    halt();

    // Stop one cycle after a request flushes it and Jz_o holds
    wr(8'd0, 32'sd10);
    arm(32'sd65536, 9'd4);
    play_one("pre", 32'sd10, 1'b0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("flush_vld", {31'b0, Jz_valid}, 32'sd0);
    check("flush_busy", {31'b0, busy}, 32'sd0);
    check("flush_hold", Jz_o, 32'sd10);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(); tick();
    check("idle_step", {31'b0, Jz_valid}, 32'sd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("ss_busy", {31'b0, busy}, 32'sd0);

    // Reset during back-to-back playback, then replay from index 0
    arm(32'sd65536, 9'd4);
    step_req = 1'b1;
    tick(); tick(); tick();
    check("rr_vld", {31'b0, Jz_valid}, 32'sd1);
    check("rr_jz", Jz_o, 32'sd10);
    RST = 1'b1;
    tick();
    check("rr_rst_vld", {31'b0, Jz_valid}, 32'sd0);
    check("rr_rst_jz", Jz_o, 32'sd0);
    check("rr_rst_done", {31'b0, done}, 32'sd0);
    check("rr_rst_busy", {31'b0, busy}, 32'sd0);
    RST = 1'b0; step_req = 1'b0;
    tick();
    arm(32'sd65536, 9'd4);
    play_one("rp0", 32'sd10, 1'b0);
    play_one("rp1", -32'sd20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
